// File: rtl/instr_trace_fifo.sv
// Instruction trace FIFO: captures {PC, Instr} whenever the executing PC
// changes while capture is enabled, and presents entries to a consumer
// through a valid/ready read port. Captures that find the FIFO full are
// dropped, counted (saturating) and flagged with a sticky overflow bit.
module instr_trace_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              Instr,
    input  logic [31:0]              PC,
    input  logic                     cap_en,
    input  logic                     clear,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [31:0]              rd_pc,
    output logic [31:0]              rd_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [63:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [31:0]    last_pc;
    logic           first;

    logic           cap_req;
    logic           rd_fire;
    logic           wr_fire;
    logic           drop;

    // Capture/read decisions for the current cycle; clear overrides both
    always_comb begin
        cap_req = cap_en && (first || (PC != last_pc));
        rd_fire = !clear && (count != '0) && rd_ready;
        // A full FIFO still accepts a capture when the head leaves in the same cycle
        wr_fire = !clear && cap_req && ((count != FULL_CNT) || rd_fire);
        drop    = !clear && cap_req && !wr_fire;
    end

    // Read port is a pure function of registered state; zero while empty
    always_comb begin
        rd_valid = (count != '0);
        rd_pc    = '0;
        rd_instr = '0;
        if (count != '0) begin
            rd_pc    = mem[rd_ptr][63:32];
            rd_instr = mem[rd_ptr][31:0];
        end
    end

    // Entry storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= {PC, Instr};
        end
    end

    // Pointers, occupancy, capture-dedup state and drop status
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            last_pc  <= '0;
            first    <= 1'b1;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            first    <= 1'b1;
        end else begin
            // Dedup state advances on every request, accepted or dropped
            if (cap_req) begin
                last_pc <= PC;
                first   <= 1'b0;
            end
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_trace_fifo.sv
// Bench for instr_trace_fifo: directed scenarios with fixed expectations plus
// a randomized run compared cycle by cycle against a queue-based model.
module tb_instr_trace_fifo;

    localparam int DEPTH = 16;
    localparam int CNT_W = 3;
    localparam int CW    = 5;
    localparam int MAXD  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       Instr;
    logic [31:0]       PC;
    logic              cap_en;
    logic              clear;
    logic              rd_ready;
    logic              rd_valid;
    logic [31:0]       rd_pc;
    logic [31:0]       rd_instr;
    logic [CW-1:0]     count;
    logic              overflow;
    logic [CNT_W-1:0]  drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [63:0] mq[$];
    bit          m_ovf;
    int          m_drops;
    logic [31:0] m_last;
    bit          m_first;

    logic [73:0] dut_vec;
    assign dut_vec = {rd_valid, rd_pc, rd_instr, count, overflow, drop_cnt};

    instr_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .Instr    (Instr),
        .PC       (PC),
        .cap_en   (cap_en),
        .clear    (clear),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_pc    (rd_pc),
        .rd_instr (rd_instr),
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [73:0] exp_vec();
        logic [63:0] h;
        h = '0;
        if (mq.size() != 0) h = mq[0];
        return {(mq.size() != 0), h, CW'(mq.size()), m_ovf, CNT_W'(m_drops)};
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_ovf   = 0;
        m_drops = 0;
        m_last  = '0;
        m_first = 1;
    endfunction

    // advance model from current inputs, then take one clock edge
    task automatic cycle();
        bit req, rd, full;
        if (clear) begin
            mq.delete();
            m_ovf   = 0;
            m_drops = 0;
            m_first = 1;
        end else begin
            req  = cap_en && (m_first || PC != m_last);
            rd   = (mq.size() != 0) && rd_ready;
            full = (mq.size() == DEPTH);
            if (req) begin
                m_last  = PC;
                m_first = 0;
            end
            if (rd) void'(mq.pop_front());
            if (req) begin
                if (!full || rd) mq.push_back({PC, Instr});
                else begin
                    m_ovf = 1;
                    if (m_drops < MAXD) m_drops++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit cap, input logic [31:0] pc, input logic [31:0] ins,
                         input bit rr, input bit clr);
        cap_en = cap; PC = pc; Instr = ins; rd_ready = rr; clear = clr;
    endtask

    task automatic do_clear();
        drive(0, PC, Instr, 0, 1);
        cycle();
        clear = 0;
    endtask

    task automatic test_reset();
        drive(0, 32'h0, 32'h0, 0, 0);
        reset = 0;
        model_reset();
        #12;
        n_tests++;
        if (dut_vec !== 74'd0) begin
            n_fail++; $display("FAIL reset_state: got %h want 0", dut_vec);
        end
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;
        n_tests++;
        if (count !== 5'd0 || rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got count=%0d valid=%0b want 0 0", count, rd_valid);
        end
    endtask

    task automatic test_single_hold();
        drive(1, 32'h0, 32'hE0400000, 0, 0);
        cycle();
        n_tests++;
        if (rd_valid !== 1'b1) begin
            n_fail++; $display("FAIL single_visible: got valid=%0b want 1", rd_valid);
        end
        cycle();
        cycle();
        n_tests++;
        if (count !== 5'd1 || rd_pc !== 32'h0 || rd_instr !== 32'hE0400000) begin
            n_fail++;
            $display("FAIL single_hold: got count=%0d pc=%h instr=%h want 1 00000000 e0400000",
                     count, rd_pc, rd_instr);
        end
    endtask

    task automatic test_loop();
        logic [31:0] pcs [5];
        logic [31:0] ins [5];
        pcs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h8};
        ins = '{32'hE0400000, 32'hE2801007, 32'hE5801064, 32'hE5902064, 32'hE5801064};
        do_clear();
        for (int i = 0; i < 5; i++) begin
            drive(1, pcs[i], ins[i], 0, 0);
            cycle();
        end
        n_tests++;
        if (count !== 5'd5) begin
            n_fail++; $display("FAIL loop_count: got %0d want 5", count);
        end
        drive(0, 32'h8, 32'hE5801064, 1, 0);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (rd_pc !== pcs[i] || rd_instr !== ins[i]) begin
                n_fail++;
                $display("FAIL loop_read%0d: got %h/%h want %h/%h", i, rd_pc, rd_instr, pcs[i], ins[i]);
            end
            cycle();
        end
        n_tests++;
        if (rd_valid !== 1'b0 || rd_pc !== 32'h0) begin
            n_fail++; $display("FAIL loop_empty: got valid=%0b pc=%h want 0 0", rd_valid, rd_pc);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] saved [16];
        do_clear();
        for (int i = 0; i < 20; i++) begin
            drive(1, 32'h100 + 32'(4*i), $urandom, 0, 0);
            if (i < 16) saved[i] = Instr;
            cycle();
        end
        n_tests++;
        if (count !== 5'd16 || overflow !== 1'b1 || drop_cnt !== 3'd4) begin
            n_fail++;
            $display("FAIL overflow_status: got count=%0d ovf=%0b drops=%0d want 16 1 4",
                     count, overflow, drop_cnt);
        end
        for (int i = 20; i < 25; i++) begin
            drive(1, 32'h100 + 32'(4*i), $urandom, 0, 0);
            cycle();
        end
        n_tests++;
        if (drop_cnt !== 3'd7) begin
            n_fail++; $display("FAIL drop_saturate: got %0d want 7", drop_cnt);
        end
        drive(0, PC, Instr, 1, 0);
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (rd_pc !== 32'h100 + 32'(4*i) || rd_instr !== saved[i]) begin
                n_fail++;
                $display("FAIL overflow_entry%0d: got %h/%h want %h/%h",
                         i, rd_pc, rd_instr, 32'h100 + 32'(4*i), saved[i]);
            end
            cycle();
        end
        cycle();
        cycle();
        n_tests++;
        if (count !== 5'd0 || overflow !== 1'b1 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL underflow_sticky: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_full_rw();
        do_clear();
        for (int i = 0; i < 16; i++) begin
            drive(1, 32'h200 + 32'(4*i), 32'hA000_0000 + 32'(i), 0, 0);
            cycle();
        end
        drive(1, 32'h300, 32'hBEEF0300, 1, 0);
        cycle();
        n_tests++;
        if (count !== 5'd16 || overflow !== 1'b0 || rd_pc !== 32'h204) begin
            n_fail++;
            $display("FAIL full_rw: got count=%0d ovf=%0b head=%h want 16 0 00000204",
                     count, overflow, rd_pc);
        end
        drive(0, PC, Instr, 1, 0);
        for (int i = 0; i < 15; i++) cycle();
        n_tests++;
        if (rd_pc !== 32'h300 || rd_instr !== 32'hBEEF0300 || count !== 5'd1) begin
            n_fail++;
            $display("FAIL full_rw_tail: got %h/%h count=%0d want 00000300/beef0300 1",
                     rd_pc, rd_instr, count);
        end
        cycle();
    endtask

    task automatic test_clear_priority();
        do_clear();
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h400 + 32'(4*i), $urandom, 0, 0);
            cycle();
        end
        drive(1, 32'h500, 32'h12345678, 1, 1);
        cycle();
        n_tests++;
        if (count !== 5'd0 || rd_valid !== 1'b0 || overflow !== 1'b0 || rd_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL clear_priority: got count=%0d valid=%0b ovf=%0b want 0 0 0",
                     count, rd_valid, overflow);
        end
        drive(1, 32'h500, 32'h12345678, 0, 0);
        cycle();
        n_tests++;
        if (count !== 5'd1 || rd_pc !== 32'h500) begin
            n_fail++; $display("FAIL clear_first: got count=%0d pc=%h want 1 00000500", count, rd_pc);
        end
    endtask

    task automatic test_reset_midcycle();
        do_clear();
        for (int i = 0; i < 7; i++) begin
            drive(1, 32'h600 + 32'(4*i), $urandom, 0, 0);
            cycle();
        end
        cap_en = 0;
        #3;
        reset = 0;
        model_reset();
        #1;
        n_tests++;
        if (dut_vec !== 74'd0) begin
            n_fail++; $display("FAIL reset_async: got %h want 0", dut_vec);
        end
        #2;
        reset = 1;
        cycle();
        n_tests++;
        if (count !== 5'd0) begin
            n_fail++; $display("FAIL reset_after: got %0d want 0", count);
        end
        drive(1, 32'h0, 32'hCAFE0000, 0, 0);
        cycle();
        n_tests++;
        if (count !== 5'd1 || rd_instr !== 32'hCAFE0000) begin
            n_fail++; $display("FAIL reset_first_cap: got count=%0d instr=%h want 1 cafe0000", count, rd_instr);
        end
    endtask

    task automatic test_random();
        int rd_pct;
        rd_pct = 50;
        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0) rd_pct = (i / 100) % 3 == 0 ? 10 : ((i / 100) % 3 == 1 ? 90 : 45);
            drive(($urandom % 8) != 0, 32'($urandom_range(0, 15)) * 4, $urandom,
                  ($urandom % 100) < rd_pct, ($urandom % 97) == 0);
            cycle();
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random_c%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        reset = 0;
        drive(0, 32'h0, 32'h0, 0, 0);
        test_reset();
        test_single_hold();
        test_loop();
        test_overflow();
        test_full_rw();
        test_clear_priority();
        test_reset_midcycle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
